pcf8575: RTL and testbench

//  I2C master that mirrors a 16-bit register onto a PCF8575 quasi-bidirectional I/O expander.
//  - Any change of wdata is written to the expander ports.
//  - A rising edge of int_sig reads the port pins back into rdata.
//  - Sits between core logic and the board-level open-drain I2C bus, which has external pull-ups.

---
 rtl/pcf8575.sv | 243 ++++++++++++++++++++++++
 tb/tb_pcf8575.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pcf8575.sv
// I2C master that mirrors a 16-bit register onto a PCF8575 I/O expander and reads it back on int_sig edges.
// Latency: a write or read starts at most 4*QTR_CYC clocks after the bus goes idle; one transaction is ~29 bit times.
// Backpressure: SCL clock stretching by the slave freezes the phase counter; requests queue as pending flags.
module pcf8575 #(
    parameter int QTR_CYC = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [2:0]  addr,
    input  logic [15:0] wdata,
    output logic [15:0] rdata,
    inout  wire         SDA_bus,
    inout  wire         SCL_bus,
    input  logic        int_sig
);

    localparam int QW       = (QTR_CYC > 1) ? $clog2(QTR_CYC) : 1;
    localparam int IW       = $clog2(4 * QTR_CYC + 1);
    localparam logic [QW-1:0] Q_MAX    = QW'(QTR_CYC - 1);
    localparam logic [IW-1:0] IDLE_MAX = IW'(4 * QTR_CYC);

    typedef enum logic [3:0] {
        S_IDLE,
        S_START,
        S_ADDR,
        S_ADDR_ACK,
        S_WR_BYTE,
        S_WR_ACK,
        S_RD_BYTE,
        S_RD_ACK,
        S_STOP
    } state_t;

    state_t          state;
    logic [1:0]      ph;        // quarter-period phase within the current bit
    logic [QW-1:0]   qcnt;      // clocks within the current phase
    logic [IW-1:0]   idle_cnt;  // bus-free time accumulated in IDLE
    logic [2:0]      bitn;
    logic            byte_idx;
    logic [7:0]      sh;        // outgoing byte, MSB on the wire
    logic [7:0]      rsh;       // incoming byte being assembled
    logic [7:0]      rx_lo;     // first read byte, held until the read completes
    logic [15:0]     wlat;      // wdata captured at START
    logic [15:0]     shadow;    // value last confirmed written to the expander
    logic            rd_op;
    logic            rd_pend;
    logic            smp;       // SDA sampled at the end of the first high phase
    logic            scl_low;
    logic            sda_low;
    logic            int_s1, int_s2, int_s3;
    logic            int_edge;
    logic            wr_pend;
    logic            hold;
    logic            bit_now;
    logic            sda_in;
    logic            scl_in;

    // Open-drain drivers: only ever pull low, the board pull-ups supply the high level
    assign SDA_bus = sda_low ? 1'b0 : 1'bz;
    assign SCL_bus = scl_low ? 1'b0 : 1'bz;
    assign sda_in  = SDA_bus;
    assign scl_in  = SCL_bus;

    assign wr_pend  = (wdata != shadow);
    assign int_edge = int_s2 & ~int_s3;
    // A slave holding SCL low while we have released it stretches the clock
    assign hold     = (state != S_IDLE) && !scl_low && !scl_in;

    // Line levels for a given state/phase, returned as {scl_low, sda_low}
    function automatic logic [1:0] lines(input state_t s, input logic [1:0] p, input logic b);
        logic [1:0] r;
        case (s)
            S_IDLE:  r = 2'b00;
            S_START: r = {p[1], 1'b1};
            S_STOP:  r = {~p[1], (p != 2'd3)};
            default: r = {~p[1], ~b};
        endcase
        return r;
    endfunction

    // Data level the master presents during the current bit (1 = released)
    always_comb begin
        bit_now = 1'b1;
        case (state)
            S_ADDR, S_WR_BYTE: bit_now = sh[7];
            S_RD_ACK:          bit_now = byte_idx;
            default:           bit_now = 1'b1;
        endcase
    end

    // Two-flop synchronizer for int_sig plus a delay flop for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            int_s1 <= 1'b0;
            int_s2 <= 1'b0;
            int_s3 <= 1'b0;
        end else begin
            int_s1 <= int_sig;
            int_s2 <= int_s1;
            int_s3 <= int_s2;
        end
    end

    // Transaction FSM: bit timing, request arbitration and registered bus drive
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            ph       <= 2'd0;
            qcnt     <= '0;
            idle_cnt <= '0;
            bitn     <= 3'd0;
            byte_idx <= 1'b0;
            sh       <= 8'h00;
            rsh      <= 8'h00;
            rx_lo    <= 8'h00;
            wlat     <= 16'hFFFF;
            shadow   <= 16'hFFFF;
            rdata    <= 16'hFFFF;
            rd_op    <= 1'b0;
            rd_pend  <= 1'b0;
            smp      <= 1'b1;
            scl_low  <= 1'b0;
            sda_low  <= 1'b0;
        end else begin
            if (state == S_IDLE) begin
                qcnt <= '0;
                ph   <= 2'd0;
                if (idle_cnt != IDLE_MAX) begin
                    idle_cnt <= idle_cnt + 1'b1;
                end else if (wr_pend || rd_pend) begin
                    // Writes win over reads; the address byte carries R/W in its LSB
                    state <= S_START;
                    rd_op <= !wr_pend;
                    sh    <= {4'b0100, addr, !wr_pend};
                    wlat  <= wdata;
                    if (!wr_pend) rd_pend <= 1'b0;
                    {scl_low, sda_low} <= lines(S_START, 2'd0, 1'b1);
                end
            end else if (!hold) begin
                if (qcnt != Q_MAX) begin
                    qcnt <= qcnt + 1'b1;
                end else begin
                    qcnt <= '0;
                    if (ph == 2'd2) begin
                        smp <= sda_in;
                        if (state == S_RD_BYTE) rsh <= {rsh[6:0], sda_in};
                    end
                    if (ph != 2'd3) begin
                        ph <= ph + 2'd1;
                        {scl_low, sda_low} <= lines(state, ph + 2'd1, bit_now);
                    end else begin
                        ph <= 2'd0;
                        case (state)
                            S_START: begin
                                state <= S_ADDR;
                                bitn  <= 3'd0;
                                {scl_low, sda_low} <= lines(S_ADDR, 2'd0, sh[7]);
                            end
                            S_ADDR, S_WR_BYTE: begin
                                sh <= {sh[6:0], 1'b0};
                                if (bitn == 3'd7) begin
                                    state <= (state == S_ADDR) ? S_ADDR_ACK : S_WR_ACK;
                                    {scl_low, sda_low} <= lines(S_ADDR_ACK, 2'd0, 1'b1);
                                end else begin
                                    bitn <= bitn + 3'd1;
                                    {scl_low, sda_low} <= lines(state, 2'd0, sh[6]);
                                end
                            end
                            S_ADDR_ACK: begin
                                bitn     <= 3'd0;
                                byte_idx <= 1'b0;
                                if (smp) begin
                                    state <= S_STOP;
                                    {scl_low, sda_low} <= lines(S_STOP, 2'd0, 1'b1);
                                end else if (rd_op) begin
                                    state <= S_RD_BYTE;
                                    {scl_low, sda_low} <= lines(S_RD_BYTE, 2'd0, 1'b1);
                                end else begin
                                    state <= S_WR_BYTE;
                                    sh    <= wlat[7:0];
                                    {scl_low, sda_low} <= lines(S_WR_BYTE, 2'd0, wlat[7]);
                                end
                            end
                            S_WR_ACK: begin
                                if (smp) begin
                                    // Shadow untouched, so the write is retried from IDLE
                                    state <= S_STOP;
                                    {scl_low, sda_low} <= lines(S_STOP, 2'd0, 1'b1);
                                end else if (!byte_idx) begin
                                    state    <= S_WR_BYTE;
                                    sh       <= wlat[15:8];
                                    byte_idx <= 1'b1;
                                    bitn     <= 3'd0;
                                    {scl_low, sda_low} <= lines(S_WR_BYTE, 2'd0, wlat[15]);
                                end else begin
                                    shadow <= wlat;
                                    state  <= S_STOP;
                                    {scl_low, sda_low} <= lines(S_STOP, 2'd0, 1'b1);
                                end
                            end
                            S_RD_BYTE: begin
                                if (bitn == 3'd7) begin
                                    state <= S_RD_ACK;
                                    {scl_low, sda_low} <= lines(S_RD_ACK, 2'd0, byte_idx);
                                end else begin
                                    bitn <= bitn + 3'd1;
                                    {scl_low, sda_low} <= lines(S_RD_BYTE, 2'd0, 1'b1);
                                end
                            end
                            S_RD_ACK: begin
                                if (!byte_idx) begin
                                    rx_lo    <= rsh;
                                    byte_idx <= 1'b1;
                                    bitn     <= 3'd0;
                                    state    <= S_RD_BYTE;
                                    {scl_low, sda_low} <= lines(S_RD_BYTE, 2'd0, 1'b1);
                                end else begin
                                    // Both bytes land together so rdata never shows a half update
                                    rdata <= {rsh, rx_lo};
                                    state <= S_STOP;
                                    {scl_low, sda_low} <= lines(S_STOP, 2'd0, 1'b1);
                                end
                            end
                            S_STOP: begin
                                state    <= S_IDLE;
                                idle_cnt <= '0;
                                {scl_low, sda_low} <= lines(S_IDLE, 2'd0, 1'b1);
                            end
                            default: begin
                                state    <= S_IDLE;
                                idle_cnt <= '0;
                                {scl_low, sda_low} <= 2'b00;
                            end
                        endcase
                    end
                end
            end
            // A new edge always wins, even on the cycle a read is being launched
            if (int_edge) rd_pend <= 1'b1;
        end
    end

endmodule

// File: tb/tb_pcf8575.sv
// Bench for pcf8575: a behavioural I2C slave decodes the bus into an event log.
// Expected logs are built from transaction-level rules and compared event by event.
// Randomized writes and reads follow the directed cases.
module tb_pcf8575;

    localparam int EV_S = 'h100;
    localparam int EV_P = 'h200;
    localparam int EV_A = 'h300;

    logic        clk;
    logic        rst_n;
    logic [2:0]  addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
    logic        int_sig;
    wire         sda;
    wire         scl;

    logic        slv_low;
    logic        slv_present;
    logic [15:0] slv_val;

    int ev_q[$];
    int exp_q[$];
    int vec_cnt;
    int err_cnt;
    logic [15:0] exp_rdata;
    logic [15:0] mdl_shadow;

    pullup (sda);
    pullup (scl);
    assign sda = slv_low ? 1'b0 : 1'bz;

    pcf8575 #(.QTR_CYC(2)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .addr    (addr),
        .wdata   (wdata),
        .rdata   (rdata),
        .SDA_bus (sda),
        .SCL_bus (scl),
        .int_sig (int_sig)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural slave and bus decoder
    logic       p_scl = 1'b1;
    logic       p_sda = 1'b1;
    logic       m_act = 1'b0;
    int         m_bit = 0;
    int         m_byte = 0;
    logic       m_rd = 1'b0;
    logic       m_go = 1'b0;
    logic [7:0] m_cur = 8'h00;

    always @(negedge clk) begin
        if (scl && p_scl && p_sda && !sda) begin
            m_act = 1'b1; m_bit = 0; m_byte = 0; m_rd = 1'b0; m_go = 1'b0; slv_low = 1'b0;
            ev_q.push_back(EV_S);
        end else if (scl && p_scl && !p_sda && sda) begin
            m_act = 1'b0; slv_low = 1'b0;
            ev_q.push_back(EV_P);
        end else if (m_act && !p_scl && scl) begin
            if (m_bit < 8) begin
                m_cur = {m_cur[6:0], sda};
                m_bit++;
                if (m_bit == 8) ev_q.push_back(int'(m_cur));
            end else begin
                ev_q.push_back(EV_A | int'(sda));
                if (m_byte == 0) begin
                    m_rd = m_cur[0];
                    m_go = m_cur[0] && !sda;
                end else if (m_rd && sda) begin
                    m_go = 1'b0;
                end
                m_byte++;
                m_bit = 0;
            end
        end else if (m_act && p_scl && !scl) begin
            if (m_bit == 8) begin
                if (m_byte == 0) slv_low = slv_present && (m_cur[7:1] == {4'b0100, addr});
                else             slv_low = !m_rd && slv_present;
            end else if (m_go && m_byte >= 1 && m_byte <= 2) begin
                slv_low = !slv_val[8*(m_byte-1) + 7 - m_bit];
            end else begin
                slv_low = 1'b0;
            end
        end
        p_scl = scl;
        p_sda = sda;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Expected bus events for one write attempt
    function automatic void push_wr(input logic [2:0] a, input logic [15:0] d, input bit present);
        exp_q.push_back(EV_S);
        exp_q.push_back('h40 + 2 * int'(a));
        if (!present) begin
            exp_q.push_back(EV_A | 1);
            exp_q.push_back(EV_P);
            return;
        end
        exp_q.push_back(EV_A);
        exp_q.push_back(int'(d[7:0]));
        exp_q.push_back(EV_A);
        exp_q.push_back(int'(d[15:8]));
        exp_q.push_back(EV_A);
        exp_q.push_back(EV_P);
    endfunction

    // Expected bus events for one read attempt
    function automatic void push_rd(input logic [2:0] a, input logic [15:0] v, input bit present);
        exp_q.push_back(EV_S);
        exp_q.push_back('h41 + 2 * int'(a));
        if (!present) begin
            exp_q.push_back(EV_A | 1);
            exp_q.push_back(EV_P);
            return;
        end
        exp_q.push_back(EV_A);
        exp_q.push_back(int'(v[7:0]));
        exp_q.push_back(EV_A);
        exp_q.push_back(int'(v[15:8]));
        exp_q.push_back(EV_A | 1);
        exp_q.push_back(EV_P);
    endfunction

    task automatic expect_bus(input string tag);
        int n;
        n = exp_q.size();
        for (int i = 0; i < 4000 && ev_q.size() < n; i++) wait_clk(1);
        chk({tag, "_count"}, ev_q.size(), n);
        for (int i = 0; i < n; i++)
            chk($sformatf("%s_ev%0d", tag, i), (i < ev_q.size()) ? ev_q[i] : -1, exp_q[i]);
        ev_q.delete();
        exp_q.delete();
    endtask

    task automatic quiet(input string tag, input int n);
        wait_clk(n);
        chk({tag, "_quiet"}, ev_q.size(), 0);
        ev_q.delete();
    endtask

    task automatic pulse_int();
        int_sig = 1'b1;
        wait_clk(4);
        int_sig = 1'b0;
    endtask

    initial begin
        vec_cnt = 0; err_cnt = 0;
        rst_n = 1'b0; addr = 3'd0; wdata = 16'hFFFF; int_sig = 1'b0;
        slv_low = 1'b0; slv_present = 1'b1; slv_val = 16'hFFFF;
        exp_rdata = 16'hFFFF; mdl_shadow = 16'hFFFF;

        // Reset state
        wait_clk(5);
        chk("rst_rdata", rdata, 16'hFFFF);
        chk("rst_sda", sda, 1'b1);
        chk("rst_scl", scl, 1'b1);
        rst_n = 1'b1;
        quiet("rst", 100);

        // Single write
        wdata = 16'hF55F; mdl_shadow = wdata;
        push_wr(3'd0, 16'hF55F, 1'b1);
        expect_bus("wr1");
        quiet("wr1", 150);
        chk("wr1_rdata", rdata, exp_rdata);

        // Read of all-ones
        slv_val = 16'hFFFF;
        pulse_int();
        push_rd(3'd0, 16'hFFFF, 1'b1);
        expect_bus("rd1");
        chk("rd1_rdata", rdata, 16'hFFFF);

        // Read of 0x1234: rdata must hold until STOP
        slv_val = 16'h1234;
        pulse_int();
        for (int i = 0; i < 4000 && ev_q.size() < 7; i++) wait_clk(1);
        chk("rd2_hold", rdata, exp_rdata);
        push_rd(3'd0, 16'h1234, 1'b1);
        expect_bus("rd2");
        wait_clk(4);
        exp_rdata = 16'h1234;
        chk("rd2_rdata", rdata, exp_rdata);
        quiet("rd2", 100);

        // Non-zero address pins
        addr = 3'b101;
        wdata = 16'h00A5; mdl_shadow = wdata;
        push_wr(3'd5, 16'h00A5, 1'b1);
        expect_bus("wr_addr5");

        // No slave: write retries until the slave appears
        slv_present = 1'b0;
        wdata = 16'hBEEF;
        push_wr(3'd5, 16'hBEEF, 1'b0);
        push_wr(3'd5, 16'hBEEF, 1'b0);
        expect_bus("nack_wr");
        slv_present = 1'b1;
        chk("nack_rdata", rdata, exp_rdata);
        push_wr(3'd5, 16'hBEEF, 1'b1);
        expect_bus("retry_wr");
        mdl_shadow = wdata;
        quiet("retry", 100);

        // Failed read is dropped
        slv_present = 1'b0;
        pulse_int();
        push_rd(3'd5, 16'h0000, 1'b0);
        expect_bus("nack_rd");
        quiet("nack_rd", 150);
        chk("nack_rd_rdata", rdata, exp_rdata);
        slv_present = 1'b1;

        // Reset during a data byte releases the bus immediately
        wdata = 16'h1357;
        for (int i = 0; i < 4000 && ev_q.size() < 3; i++) wait_clk(1);
        wait_clk(12);
        rst_n = 1'b0;
        #1;
        chk("midrst_sda", sda, 1'b1);
        chk("midrst_scl", scl, 1'b1);
        exp_rdata = 16'hFFFF;
        chk("midrst_rdata", rdata, exp_rdata);
        wait_clk(3);
        ev_q.delete();
        rst_n = 1'b1;
        push_wr(3'd5, 16'h1357, 1'b1);
        expect_bus("post_rst");
        mdl_shadow = wdata;

        // wdata changes during a write: old value completes, new value follows
        wdata = 16'hA1B2;
        for (int i = 0; i < 4000 && ev_q.size() < 1; i++) wait_clk(1);
        wait_clk(20);
        wdata = 16'hC3D4;
        push_wr(3'd5, 16'hA1B2, 1'b1);
        push_wr(3'd5, 16'hC3D4, 1'b1);
        expect_bus("chg_wr");
        mdl_shadow = wdata;

        // Write has priority over a simultaneous read request
        slv_val = 16'h5AC3;
        wdata = 16'h0F0F;
        pulse_int();
        push_wr(3'd5, 16'h0F0F, 1'b1);
        push_rd(3'd5, 16'h5AC3, 1'b1);
        expect_bus("prio");
        mdl_shadow = wdata;
        exp_rdata = 16'h5AC3;
        wait_clk(4);
        chk("prio_rdata", rdata, exp_rdata);

        // Randomized traffic
        for (int it = 0; it < 10; it++) begin
            logic [15:0] d;
            bit pres;
            addr = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 1) == 0) begin
                d = 16'($urandom);
                if (d == mdl_shadow) d = d ^ 16'h0001;
                wdata = d;
                push_wr(addr, d, 1'b1);
                expect_bus($sformatf("rnd%0d_wr", it));
                mdl_shadow = d;
            end else begin
                pres = ($urandom_range(0, 3) != 0);
                slv_present = pres;
                slv_val = 16'($urandom);
                pulse_int();
                push_rd(addr, slv_val, pres);
                expect_bus($sformatf("rnd%0d_rd", it));
                if (pres) exp_rdata = slv_val;
                wait_clk(4);
                slv_present = 1'b1;
            end
            chk($sformatf("rnd%0d_rdata", it), rdata, exp_rdata);
            wait_clk(30);
        end
        quiet("end", 100);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
